// File: rtl/io_dev_bank_if.sv
// Core-to-device I/O bus: level request with held controls, single-cycle ack/fault response.
interface io_dev_bank_if #(
  parameter int A_SZ = 32,
  parameter int D_SZ = 32
) ();
  logic            io_req;
  logic            io_rd;
  logic            io_wr;
  logic [A_SZ-1:0] io_addr;
  logic [D_SZ-1:0] io_wr_data;
  logic            io_ack;
  logic            io_ack_fault;
  logic [D_SZ-1:0] io_rd_data;

  modport master (
    output io_req, io_rd, io_wr, io_addr, io_wr_data,
    input  io_ack, io_ack_fault, io_rd_data
  );

  modport slave (
    input  io_req, io_rd, io_wr, io_addr, io_wr_data,
    output io_ack, io_ack_fault, io_rd_data
  );
endinterface

// File: rtl/io_dev_bank.sv
// Memory-mapped bank of NUM_CH channels (scratch, compare timer, interrupt) behind the
// core's external I/O port, with a fixed-latency request/response FSM and merged ext_irq.

module io_dev_ch #(
  parameter int D_SZ = 32
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            i_we,
  input  logic [1:0]      i_wreg,
  input  logic [D_SZ-1:0] i_wdata,
  input  logic [1:0]      i_rreg,
  output logic [D_SZ-1:0] o_rdata,
  output logic            o_irq
);
  logic [D_SZ-1:0] r_data, r_timer, r_cmp;
  logic            r_en, r_ie, r_pend;
  logic            w_match;

  assign w_match = r_en && (r_timer == r_cmp);
  assign o_irq   = r_pend & r_ie;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_data  <= '0;
      r_timer <= '0;
      r_cmp   <= '0;
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (i_we && i_wreg == 2'd0) r_data <= i_wdata;
      if (i_we && i_wreg == 2'd2) r_cmp  <= i_wdata;
      // a bus load of the count takes priority over the free-running increment
      if (i_we && i_wreg == 2'd1)  r_timer <= i_wdata;
      else if (r_en)               r_timer <= r_timer + D_SZ'(1);
      if (i_we && i_wreg == 2'd3) begin
        r_en <= i_wdata[0];
        r_ie <= i_wdata[1];
      end
      // a fresh match must not be lost to a simultaneous W1C
      if (w_match)                                    r_pend <= 1'b1;
      else if (i_we && i_wreg == 2'd3 && i_wdata[2])  r_pend <= 1'b0;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_rreg)
      2'd0: o_rdata = r_data;
      2'd1: o_rdata = r_timer;
      2'd2: o_rdata = r_cmp;
      default: o_rdata[2:0] = {r_pend, r_ie, r_en};
    endcase
  end
endmodule

module io_dev_bank #(
  parameter int              A_SZ      = 32,
  parameter int              D_SZ      = 32,
  parameter int              NUM_CH    = 4,
  parameter logic [A_SZ-1:0] BASE_ADDR = A_SZ'(32'hFFFF_0000),
  parameter int              ACK_LAT   = 2
) (
  input  logic               clk_in,
  input  logic               reset_in,
  io_dev_bank_if.slave       bus,
  output logic               ext_irq
);
  localparam int              CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              CW  = $clog2(ACK_LAT + 1);
  localparam logic [A_SZ-1:0] WIN = A_SZ'(16 * NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [CHW-1:0]  ch;
    logic [1:0]      rg;
    logic            rd;
    logic            wr;
    logic            fault;
    logic [D_SZ-1:0] wdata;
  } req_t;

  state_t                       r_state, w_state_nx;
  logic [CW-1:0]                r_cnt, w_cnt_nx;
  req_t                         r_req;
  logic [D_SZ-1:0]              r_rdata;
  logic                         r_irq;

  logic [A_SZ-1:0]              w_off;
  logic [CHW-1:0]               w_ch, w_rsel_ch;
  logic [1:0]                   w_rsel_reg;
  logic                         w_fault, w_load, w_rd_ok, w_enter_resp, w_we;
  logic [NUM_CH-1:0][D_SZ-1:0]  w_rd_ch;
  logic [NUM_CH-1:0]            w_irq;

  // offset wraps, so addresses below the base land far outside the window
  assign w_off   = bus.io_addr - BASE_ADDR;
  assign w_ch    = (NUM_CH > 1) ? w_off[4 +: CHW] : '0;
  assign w_fault = (w_off >= WIN) || (w_off[1:0] != 2'b00) || (bus.io_rd == bus.io_wr);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.io_req) begin
        w_load     = 1'b1;
        w_cnt_nx   = CW'(ACK_LAT - 1);
        w_state_nx = (ACK_LAT == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nx = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nx = S_RESP;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // with ACK_LAT==1 the capture happens on the sample edge, before r_req holds the decode
  assign w_rsel_ch    = (r_state == S_IDLE) ? w_ch        : r_req.ch;
  assign w_rsel_reg   = (r_state == S_IDLE) ? w_off[3:2]  : r_req.rg;
  assign w_rd_ok      = (r_state == S_IDLE) ? (!w_fault && bus.io_rd) : (!r_req.fault && r_req.rd);
  assign w_enter_resp = (w_state_nx == S_RESP) && (r_state != S_RESP);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_irq   <= |w_irq;
      if (w_load)
        r_req <= '{ch: w_ch, rg: w_off[3:2], rd: bus.io_rd, wr: bus.io_wr,
                   fault: w_fault, wdata: bus.io_wr_data};
      if (w_enter_resp) r_rdata <= w_rd_ok ? w_rd_ch[w_rsel_ch] : '0;
    end
  end

  assign bus.io_ack       = (r_state == S_RESP) && !r_req.fault;
  assign bus.io_ack_fault = (r_state == S_RESP) &&  r_req.fault;
  assign bus.io_rd_data   = bus.io_ack ? r_rdata : '0;
  assign ext_irq          = r_irq;

  // writes commit on the edge leaving RESP
  assign w_we = (r_state == S_RESP) && !r_req.fault && r_req.wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    io_dev_ch #(.D_SZ(D_SZ)) u_ch (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .i_we     (w_we && (r_req.ch == CHW'(i))),
      .i_wreg   (r_req.rg),
      .i_wdata  (r_req.wdata),
      .i_rreg   (w_rsel_reg),
      .o_rdata  (w_rd_ch[i]),
      .o_irq    (w_irq[i])
    );
  end
endmodule

// File: tb/tb_io_dev_bank.sv
// Directed + randomized bench for io_dev_bank against a per-cycle register-level reference model.
module tb_io_dev_bank;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          NCH   = 4;
  localparam int          LAT_A = 2;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic irq_a, irq_b;
  int   checks = 0;
  int   errors = 0;

  io_dev_bank_if #(.A_SZ(32), .D_SZ(32)) aif ();
  io_dev_bank_if #(.A_SZ(32), .D_SZ(32)) bif ();

  io_dev_bank #(.NUM_CH(NCH), .BASE_ADDR(BASE), .ACK_LAT(LAT_A)) u_dut_a (
    .clk_in(clk), .reset_in(reset_in), .bus(aif), .ext_irq(irq_a));
  io_dev_bank #(.NUM_CH(NCH), .BASE_ADDR(BASE), .ACK_LAT(1)) u_dut_b (
    .clk_in(clk), .reset_in(reset_in), .bus(bif), .ext_irq(irq_b));

  always #5 clk = ~clk;

  // reference state for DUT A
  logic [31:0] m_data[NCH], m_timer[NCH], m_cmp[NCH];
  bit          m_en[NCH], m_ie[NCH], m_pend[NCH];
  bit          m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int ch, input int rg);
    case (rg)
      0: return m_data[ch];
      1: return m_timer[ch];
      2: return m_cmp[ch];
      default: return {29'd0, m_pend[ch], m_ie[ch], m_en[ch]};
    endcase
  endfunction

  // one clock edge: update the model from pre-edge values, then compare ext_irq
  task automatic tick(input bit wv, input int wch, input int wrg, input logic [31:0] wd);
    bit irq_n;
    @(posedge clk);
    if (!reset_in) begin
      for (int i = 0; i < NCH; i++) begin
        m_data[i] = 0; m_timer[i] = 0; m_cmp[i] = 0;
        m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
      end
      m_irq = 0;
    end else begin
      irq_n = 0;
      for (int i = 0; i < NCH; i++) irq_n |= m_pend[i] & m_ie[i];
      for (int i = 0; i < NCH; i++) begin
        bit hit, w;
        hit = m_en[i] && (m_timer[i] == m_cmp[i]);
        w   = wv && (wch == i);
        if (w && wrg == 1)      m_timer[i] = wd;
        else if (m_en[i])       m_timer[i] = m_timer[i] + 32'd1;
        if (w && wrg == 0)      m_data[i] = wd;
        if (w && wrg == 2)      m_cmp[i] = wd;
        if (hit)                          m_pend[i] = 1;
        else if (w && wrg == 3 && wd[2])  m_pend[i] = 0;
        if (w && wrg == 3) begin m_en[i] = wd[0]; m_ie[i] = wd[1]; end
      end
      m_irq = irq_n;
    end
    #1;
    chk("ext_irq", irq_a, m_irq);
  endtask

  // full transaction on DUT A: fixed ACK_LAT cycles to response, then the commit edge
  task automatic xact(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rdata, input string tag);
    logic [31:0] off, exp;
    bit flt;
    int ch, rg;
    off = addr - BASE;
    flt = (off >= 32'(16 * NCH)) || (off[1:0] != 2'b00) || (rd == wr);
    ch  = int'(off[5:4]);
    rg  = int'(off[3:2]);
    exp = 0;
    aif.io_req = 1; aif.io_rd = rd; aif.io_wr = wr; aif.io_addr = addr; aif.io_wr_data = wd;
    for (int k = 1; k <= LAT_A; k++) begin
      if (k == LAT_A && !flt && rd) exp = m_read(ch, rg);
      tick(0, 0, 0, 0);
      if (k < LAT_A) begin
        chk({tag, "_early_ack"}, aif.io_ack, 0);
        chk({tag, "_early_flt"}, aif.io_ack_fault, 0);
      end
    end
    chk({tag, "_ack"},   aif.io_ack, !flt);
    chk({tag, "_fault"}, aif.io_ack_fault, flt);
    chk({tag, "_rdata"}, aif.io_rd_data, exp);
    rdata = aif.io_rd_data;
    aif.io_req = 0; aif.io_rd = 0; aif.io_wr = 0;
    tick(!flt && wr, ch, rg, wd);
    chk({tag, "_ack_1cyc"}, {aif.io_ack, aif.io_ack_fault}, 0);
  endtask

  logic [31:0] rv, t0, bval[8], sb[NCH];
  int t_match, acks, last, n;
  bit seen;

  task automatic drive_b(input int k);
    bif.io_req = 1;
    bif.io_rd = k[0]; bif.io_wr = !k[0];
    bif.io_addr = BASE + 32'(16 * (k / 2));
    bif.io_wr_data = bval[k];
  endtask

  initial begin
    aif.io_req = 0; aif.io_rd = 0; aif.io_wr = 0; aif.io_addr = 0; aif.io_wr_data = 0;
    bif.io_req = 0; bif.io_rd = 0; bif.io_wr = 0; bif.io_addr = 0; bif.io_wr_data = 0;
    repeat (3) tick(0, 0, 0, 0);
    reset_in = 1;
    tick(0, 0, 0, 0);
    chk("rst_ack",   aif.io_ack, 0);
    chk("rst_fault", aif.io_ack_fault, 0);
    chk("rst_rdata", aif.io_rd_data, 0);
    chk("rst_irq",   irq_a, 0);

    // reset in the middle of a write's wait phase aborts it
    aif.io_req = 1; aif.io_wr = 1; aif.io_rd = 0; aif.io_addr = BASE; aif.io_wr_data = 32'h1234;
    tick(0, 0, 0, 0);
    reset_in = 0;
    aif.io_req = 0; aif.io_wr = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0);
      chk("rst_mid_ack", aif.io_ack, 0);
      chk("rst_mid_flt", aif.io_ack_fault, 0);
    end
    reset_in = 1;
    tick(0, 0, 0, 0);
    chk("post_rst_ack", aif.io_ack, 0);
    xact(1, 0, BASE, 0, rv, "rst_data0");
    chk("rst_data0_zero", rv, 32'h0);

    // data path
    xact(0, 1, BASE + 32'h10, 32'hA5A5_5A5A, rv, "wr_ch1");
    xact(1, 0, BASE + 32'h10, 0, rv, "rd_ch1");
    chk("rd_ch1_val", rv, 32'hA5A5_5A5A);
    for (int c = 0; c < NCH; c++)
      if (c != 1) begin
        xact(1, 0, BASE + 32'(16 * c), 0, rv, "rd_other");
        chk("rd_other_zero", rv, 32'h0);
      end

    // faults
    xact(1, 0, BASE + 32'h2, 0, rv, "flt_unal");
    xact(1, 0, BASE + 32'(16 * NCH), 0, rv, "flt_oow");
    xact(1, 1, BASE, 32'hDEAD_0001, rv, "flt_rdwr");
    xact(1, 0, BASE, 0, rv, "flt_nochg");
    chk("flt_nochg_val", rv, 32'h0);

    // timer interrupt on ch0
    xact(0, 1, BASE + 32'h8, 32'd10, rv, "cmp0");
    xact(0, 1, BASE + 32'hC, 32'd3, rv, "ctrl0");
    t_match = -1; seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      tick(0, 0, 0, 0);
      if (t_match < 0 && m_timer[0] == 32'd10) t_match = cyc;
      if (t_match >= 0 && cyc == t_match + 1) chk("irq_not_yet", irq_a, 0);
      if (t_match >= 0 && cyc == t_match + 2) begin chk("irq_2cyc", irq_a, 1); seen = 1; end
    end
    chk("irq_seen", seen, 1);
    xact(0, 1, BASE + 32'hC, 32'h7, rv, "w1c");
    tick(0, 0, 0, 0);
    chk("irq_drop", irq_a, 0);
    t0 = m_timer[0];
    xact(0, 1, BASE + 32'h8, t0 + 32'd5, rv, "cmp0_re");
    xact(0, 1, BASE + 32'hC, 32'h7, rv, "w1c_coinc");
    xact(1, 0, BASE + 32'hC, 0, rv, "rd_ctrl0");
    chk("pend_set_wins", rv, 32'h7);

    // wrap and write-over-increment on ch1
    xact(0, 1, BASE + 32'h14, 32'hFFFF_FFFE, rv, "tmr1_ld");
    xact(0, 1, BASE + 32'h1C, 32'h1, rv, "ctrl1_en");
    xact(1, 0, BASE + 32'h14, 0, rv, "tmr1_rd_a");
    chk("wrap_ffff", rv, 32'hFFFF_FFFF);
    xact(1, 0, BASE + 32'h14, 0, rv, "tmr1_rd_b");
    chk("wrap_past0", rv, 32'h2);
    xact(0, 1, BASE + 32'h14, 32'h100, rv, "tmr1_ld2");
    xact(1, 0, BASE + 32'h14, 0, rv, "tmr1_rd_c");
    chk("wr_beats_inc", rv, 32'h101);

    // randomized traffic, including faulting patterns
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, d;
      bit rd, wr;
      int sel;
      sel = int'($urandom_range(0, 15));
      a   = BASE + ($urandom_range(0, 15) << 2);
      rd  = bit'($urandom_range(0, 1));
      wr  = !rd;
      d   = $urandom;
      if (sel == 0)      a = a + 32'd1;
      else if (sel == 1) a = BASE + 32'(16 * NCH) + ($urandom_range(0, 15) << 2);
      else if (sel == 2) wr = rd;
      else if (sel == 3) a = BASE - 32'd4;
      xact(rd, wr, a, d, rv, "rnd");
    end

    // back-to-back on the ACK_LAT=1 instance
    for (int k = 0; k < 8; k++) bval[k] = $urandom;
    for (int c = 0; c < NCH; c++) sb[c] = 0;
    acks = 0; last = -1; n = 0;
    drive_b(0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick(0, 0, 0, 0);
      chk("b2b_fault", bif.io_ack_fault, 0);
      if (bif.io_ack === 1'b1) begin
        acks++;
        if (n < 8) begin
          if (last >= 0) chk("b2b_gap", cyc - last, 2);
          if (n % 2 == 1) chk("b2b_rd", bif.io_rd_data, sb[n / 2]);
          else            sb[n / 2] = bval[n];
        end
        last = cyc; n++;
        if (n < 8) drive_b(n);
        else begin bif.io_req = 0; bif.io_rd = 0; bif.io_wr = 0; end
      end
    end
    chk("b2b_count", acks, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
